// File: rtl/if_req_arbiter_if.sv
// Requester/memory bundle for if_req_arbiter: NUM_REQ forward/backward token
// ports on one side, a single shared memory-IF token pair on the other.
interface if_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int FTK_W   = 11,
  parameter int BTK_W   = 12
);
  // FTk layout: {v, a, r, data[7:0]}; BTk layout: {n, t, v, c, data[7:0]}
  logic [NUM_REQ-1:0]            header;
  logic [NUM_REQ-1:0][FTK_W-1:0] req_ftk;
  logic [NUM_REQ-1:0][BTK_W-1:0] req_btk;
  logic [FTK_W-1:0]              ftk;
  logic [BTK_W-1:0]              btk;
  logic [NUM_REQ-1:0]            grant;
  logic [2:0]                    grant_id;
  logic                          busy;
  logic                          abort;

  modport master (
    output header, req_ftk, btk,
    input  req_btk, ftk, grant, grant_id, busy, abort
  );

  modport slave (
    input  header, req_ftk, btk,
    output req_btk, ftk, grant, grant_id, busy, abort
  );
endinterface

// File: rtl/if_req_arbiter.sv
// Round-robin arbiter sharing one external memory IF between NUM_REQ store
// front-ends. Optional idle watchdog enabled by IF_REQ_ARBITER_WATCHDOG_EN.
module if_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clock,
  input  logic            reset,
  if_req_arbiter_if.slave bus
);
  localparam int FTK_W = 11;
  localparam int BTK_W = 12;
  localparam int FTK_V = 10;
  localparam int FTK_A = 9;
  localparam int FTK_R = 8;
  localparam int BTK_N = 11;
  localparam logic [BTK_W-1:0] BTK_NACK = {1'b1, {(BTK_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

  state_t             state_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic [2:0]         grant_id_reg;
  logic [2:0]         ptr_reg;
  logic               busy_reg;

  logic [FTK_W-1:0]     ftk_mux;
  logic [2*NUM_REQ-1:0] hdr_rot;
  logic                 pick_valid;
  logic [2:0]           pick_off;
  logic [3:0]           pick_sum;
  logic [2:0]           pick_idx;
  logic [2:0]           next_ptr;
  logic                 beat_accepted;
  logic                 beat_terminal;
  logic                 wd_expire;
  logic                 do_release;

  // grant_reg is all-zero outside RUN, so the mux also blanks O_FTk there
  always_comb begin
    ftk_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_reg[i]) begin
        ftk_mux = ftk_mux | bus.req_ftk[i];
      end
    end
  end

  // Rotate the request vector so the search always begins at ptr_reg
  always_comb begin
    hdr_rot    = {bus.header, bus.header} >> ptr_reg;
    pick_valid = 1'b0;
    pick_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hdr_rot[k]) begin
        pick_valid = 1'b1;
        pick_off   = 3'(k);
      end
    end
    pick_sum = {1'b0, ptr_reg} + {1'b0, pick_off};
    if (pick_sum >= 4'(NUM_REQ)) begin
      pick_sum = pick_sum - 4'(NUM_REQ);
    end
    pick_idx = pick_sum[2:0];
  end

  assign next_ptr      = (grant_id_reg == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id_reg + 3'd1;
  assign beat_accepted = ftk_mux[FTK_V] & ~bus.btk[BTK_N];
  assign beat_terminal = beat_accepted & ftk_mux[FTK_A] & ftk_mux[FTK_R];

`ifdef IF_REQ_ARBITER_WATCHDOG_EN
  logic [7:0] wdog_reg;
  logic       abort_reg;

  assign wd_expire = (state_reg == RUN) && !beat_accepted &&
                     (({1'b0, wdog_reg} + 9'd1) >= 9'(TIMEOUT));
  assign bus.abort = abort_reg;
`else
  assign wd_expire = 1'b0;
  assign bus.abort = 1'b0;
`endif

  assign do_release = beat_terminal | wd_expire;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      grant_id_reg <= '0;
      ptr_reg      <= '0;
      busy_reg     <= 1'b0;
`ifdef IF_REQ_ARBITER_WATCHDOG_EN
      wdog_reg     <= '0;
      abort_reg    <= 1'b0;
`endif
    end else begin
`ifdef IF_REQ_ARBITER_WATCHDOG_EN
      abort_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg    <= RUN;
            grant_reg    <= NUM_REQ'(1) << pick_idx;
            grant_id_reg <= pick_idx;
            busy_reg     <= 1'b1;
`ifdef IF_REQ_ARBITER_WATCHDOG_EN
            wdog_reg     <= '0;
`endif
          end
        end
        RUN: begin
          if (do_release) begin
            state_reg <= RELEASE;
            grant_reg <= '0;
            ptr_reg   <= next_ptr;
          end
`ifdef IF_REQ_ARBITER_WATCHDOG_EN
          if (wd_expire) begin
            abort_reg <= 1'b1;
          end
          if (beat_accepted) begin
            wdog_reg <= '0;
          end else begin
            wdog_reg <= wdog_reg + 8'd1;
          end
`endif
        end
        RELEASE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_reg;
  assign bus.grant_id = grant_id_reg;
  assign bus.busy     = busy_reg;
  assign bus.ftk      = ftk_mux;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_btk
      assign bus.req_btk[gi] = grant_reg[gi] ? bus.btk : BTK_NACK;
    end
  endgenerate
endmodule

// File: tb/tb_if_req_arbiter.sv
// Self-checking bench for if_req_arbiter: directed table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_if_req_arbiter;
  localparam int N       = 4;
  localparam int TIMEOUT = 4;
`ifdef IF_REQ_ARBITER_WATCHDOG_EN
  localparam bit WD_ON  = 1'b1;
  localparam int BP_LEN = TIMEOUT - 1;
`else
  localparam bit WD_ON  = 1'b0;
  localparam int BP_LEN = 5;
`endif
  localparam logic [11:0] NACK = 12'h800;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  if_req_arbiter_if #(.NUM_REQ(N)) bus ();

  if_req_arbiter #(.NUM_REQ(N), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=hang required=finish");
    $fatal(1, "timeout");
  end

  // Reference model: who owns the memory IF, how many dead cycles remain
  // before arbitration, where the next search starts.
  int m_owner, m_gap, m_next, m_last, m_quiet;
  bit m_abort;

  task automatic reset_model();
    m_owner = -1; m_gap = 0; m_next = 0; m_last = 0; m_quiet = 0; m_abort = 1'b0;
  endtask

  function automatic logic [10:0] sel_ftk(int idx);
    logic [10:0] r = '0;
    for (int j = 0; j < N; j++) if (j == idx) r = bus.req_ftk[j];
    return r;
  endfunction

  function automatic bit hbit(logic [N-1:0] v, int idx);
    bit r = 1'b0;
    for (int j = 0; j < N; j++) if (j == idx) r = v[j];
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [10:0] f;
    logic [11:0] b;
    bit done, new_abort;
    b = bus.btk;
    new_abort = 1'b0;
    if (m_owner >= 0) begin
      f = sel_ftk(m_owner);
      done = f[10] && f[9] && f[8] && !b[11];
      if (!done && WD_ON) begin
        if (f[10] && !b[11]) m_quiet = 0;
        else m_quiet++;
        if (m_quiet >= TIMEOUT) begin
          done = 1'b1;
          new_abort = 1'b1;
        end
      end
      if (done) begin
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = 1;
      end
    end else if (m_gap > 0) begin
      m_gap = 0;
    end else if (bus.header != '0) begin
      for (int k = 0; k < N; k++) begin
        int i = (m_next + k) % N;
        if (hbit(bus.header, i)) begin
          m_owner = i; m_last = i; m_quiet = 0;
          break;
        end
      end
    end
    m_abort = new_abort;
  endtask

  task automatic check_model();
    logic [N-1:0]       eg = '0;
    logic [10:0]        ef = '0;
    logic [N-1:0][11:0] eb;
    for (int i = 0; i < N; i++) begin
      eb[i] = NACK;
      if (i == m_owner) begin
        eg[i] = 1'b1;
        ef    = bus.req_ftk[i];
        eb[i] = bus.btk;
      end
    end
    chk("grant",    64'(bus.grant),    64'(eg));
    chk("grant_id", 64'(bus.grant_id), 64'(m_last));
    chk("busy",     64'(bus.busy),     64'((m_owner >= 0) || (m_gap > 0)));
    chk("abort",    64'(bus.abort),    64'(m_abort));
    chk("ftk",      64'(bus.ftk),      64'(ef));
    chk("req_btk",  64'(bus.req_btk),  64'(eb));
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge
  task automatic cycle();
    @(negedge clock);
    check_model();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic set_all_ftk(logic [10:0] f);
    for (int i = 0; i < N; i++) bus.req_ftk[i] = f;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.header = '0;
    bus.btk = '0;
    set_all_ftk('0);
    reset_model();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_grant",    64'(bus.grant),    64'(0));
    chk("rst_grant_id", 64'(bus.grant_id), 64'(0));
    chk("rst_busy",     64'(bus.busy),     64'(0));
    chk("rst_abort",    64'(bus.abort),    64'(0));
    chk("rst_ftk",      64'(bus.ftk),      64'(0));
    chk("rst_req_btk",  64'(bus.req_btk),  {16'h0, {N{NACK}}});
    reset = 1'b0;
  endtask

  task automatic flush();
    bus.header = '0;
    bus.btk = '0;
    set_all_ftk(11'h700);
    repeat (3) cycle();
    set_all_ftk('0);
    repeat (2) cycle();
  endtask

  typedef struct {
    logic [N-1:0] hdr;
    logic [10:0]  f1;
    logic         n;
    logic [N-1:0] eg;
    logic [2:0]   egid;
    logic         ebusy;
    logic [10:0]  eftk;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int pulses, o, other, mode;
    int order [5];

    tbl[0] = '{4'b0010, 11'h000, 1'b0, 4'b0000, 3'd0, 1'b0, 11'h000};
    tbl[1] = '{4'b0010, 11'h4A1, 1'b0, 4'b0010, 3'd1, 1'b1, 11'h4A1};
    tbl[2] = '{4'b0010, 11'h4A2, 1'b0, 4'b0010, 3'd1, 1'b1, 11'h4A2};
    tbl[3] = '{4'b0000, 11'h7A3, 1'b0, 4'b0010, 3'd1, 1'b1, 11'h7A3};
    tbl[4] = '{4'b0000, 11'h000, 1'b0, 4'b0000, 3'd1, 1'b1, 11'h000};
    tbl[5] = '{4'b0000, 11'h000, 1'b0, 4'b0000, 3'd1, 1'b0, 11'h000};
    order = '{0, 1, 2, 3, 0};

    do_reset();

    // Single requester, three-beat burst
    for (int r = 0; r < 6; r++) begin
      bus.header = tbl[r].hdr;
      set_all_ftk('0);
      bus.req_ftk[1] = tbl[r].f1;
      bus.btk = {tbl[r].n, 11'h0};
      #3;
      chk($sformatf("tbl%0d_grant", r),    64'(bus.grant),    64'(tbl[r].eg));
      chk($sformatf("tbl%0d_grant_id", r), 64'(bus.grant_id), 64'(tbl[r].egid));
      chk($sformatf("tbl%0d_busy", r),     64'(bus.busy),     64'(tbl[r].ebusy));
      chk($sformatf("tbl%0d_ftk", r),      64'(bus.ftk),      64'(tbl[r].eftk));
      cycle();
    end

    // Everyone requesting: strict rotation from port 0
    do_reset();
    bus.header = 4'b1111;
    cycle();
    for (int b = 0; b < 5; b++) begin
      chk($sformatf("rr_order%0d", b), 64'(bus.grant), 64'(1 << order[b]));
      set_all_ftk(11'h411); cycle();
      set_all_ftk(11'h722); cycle();
      set_all_ftk('0);
      cycle();
      if (b == 4) bus.header = '0;
      cycle();
    end
    flush();

    // Backpressure on the terminal beat holds the grant
    bus.header = 4'b0001;
    cycle();
    bus.header = '0;
    set_all_ftk(11'h733);
    bus.btk = 12'h800;
    for (int k = 0; k < BP_LEN; k++) begin
      cycle();
      chk($sformatf("bp_hold%0d", k), 64'(bus.grant), 64'(1));
    end
    bus.btk = '0;
    cycle();
    chk("bp_release_grant", 64'(bus.grant), 64'(0));
    chk("bp_release_busy",  64'(bus.busy),  64'(1));
    set_all_ftk('0);
    cycle();
    chk("bp_idle_busy", 64'(bus.busy), 64'(0));
    flush();

    // Granted port goes quiet after one accepted beat
    bus.header = 4'b0011;
    cycle();
    o = m_owner;
    chk("wd_granted", 64'(bus.grant != '0), 64'(1));
    other = (o == 0) ? 1 : 0;
    bus.header = 4'(1 << other);
    set_all_ftk(11'h444);
    cycle();
    set_all_ftk('0);
    pulses = 0;
`ifdef IF_REQ_ARBITER_WATCHDOG_EN
    for (int k = 1; k <= TIMEOUT + 2; k++) begin
      cycle();
      if (k == TIMEOUT) chk("wd_abort_time", 64'(bus.abort), 64'(1));
      pulses += int'(bus.abort);
    end
    chk("wd_pulses", 64'(pulses), 64'(1));
    chk("wd_next_grant", 64'(bus.grant), 64'(1 << other));
`else
    for (int k = 0; k < 60; k++) begin
      cycle();
      pulses += int'(bus.abort);
    end
    chk("wd_pulses", 64'(pulses), 64'(0));
    chk("wd_held_grant", 64'(bus.grant), 64'(1 << o));
`endif
    flush();

    // Asynchronous reset in the middle of a burst
    do_reset();
    bus.header = 4'b0100;
    cycle();
    bus.header = '0;
    set_all_ftk(11'h4B1); cycle();
    set_all_ftk(11'h4B2);
    #2;
    reset = 1'b1;
    reset_model();
    #1;
    chk("arst_grant",   64'(bus.grant),   64'(0));
    chk("arst_req_btk", 64'(bus.req_btk), {16'h0, {N{NACK}}});
    chk("arst_busy",    64'(bus.busy),    64'(0));
    chk("arst_abort",   64'(bus.abort),   64'(0));
    chk("arst_ftk",     64'(bus.ftk),     64'(0));
    set_all_ftk('0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.header = 4'b1111;
    cycle();
    chk("arst_first_grant", 64'(bus.grant), 64'(1));
    flush();

    // Random traffic; the quiet phases starve the watchdog
    mode = 0;
    for (int c = 0; c < 2000; c++) begin
      if (c % 50 == 0) mode = int'($urandom_range(0, 2));
      bus.header = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        logic v, ar;
        v  = (mode == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
        ar = ($urandom_range(0, 5) == 0);
        bus.req_ftk[i] = {v, ar, ar, 8'($urandom)};
      end
      bus.btk = {($urandom_range(0, 3) == 0), 3'($urandom), 8'($urandom)};
      cycle();
    end
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_req_arbiter.md
IF_REQ_ARBITER -- requirements
Module: if_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requester ports (IF logic store front-ends); legal range 2..8.
REQ-002 Parameter TIMEOUT, 64, idle-beat limit in cycles for the watchdog (REQ-024); legal range 1..255.
REQ-003 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 I_Header  input  NUM_REQ  per-requester request flag (send request).
REQ-007 I_Req_FTk  input  NUM_REQ x FTk_t  per-requester forward token stream.
REQ-008 O_Req_BTk  output  NUM_REQ x BTk_t  per-requester backward token.
REQ-009 O_FTk  output  FTk_t  forward token to the shared external memory IF.
REQ-010 I_BTk  input  BTk_t  backward token from the shared external memory IF.
REQ-011 O_Grant  output  NUM_REQ  one-hot grant; all-zero when no grant is held.
REQ-012 O_Grant_ID  output  3  index of the granted or last-granted requester.
REQ-013 O_Busy  output  1  high in RUN and RELEASE.
REQ-014 O_Abort  output  1  one-cycle pulse on watchdog abort.

Function
REQ-015 FSM states SHALL be IDLE, RUN and RELEASE.
- IDLE->RUN when any I_Header bit is set.
- RUN->RELEASE on termination (REQ-019) or abort (REQ-024).
- RELEASE->IDLE unconditionally after one cycle.
REQ-016 Arbitration SHALL be round-robin.
- Search starts at (last granted index + 1) mod NUM_REQ.
- After reset the search starts at index 0.
REQ-017 Latency: I_Header sampled high in IDLE at edge t SHALL give O_Grant and RUN at edge t+1.
- The first forwarded beat is available in the cycle after edge t+1.
REQ-018 Routing in RUN:
- O_FTk SHALL equal I_Req_FTk[granted] combinationally.
- O_Req_BTk[granted] SHALL equal I_BTk combinationally.
- Every other port SHALL see BTk with n=1, t=0, v=0, c=0.
REQ-019 Termination SHALL be a granted beat with v&a&r=1 and I_BTk.n=0 in the same cycle.
- A beat with v&a&r=1 and I_BTk.n=1 is not a termination; the grant is held.
REQ-020 In IDLE and RELEASE:
- O_FTk SHALL be all-zero.
- Every O_Req_BTk SHALL carry n=1, t=0, v=0, c=0.
REQ-021 Deasserting I_Header[granted] during RUN SHALL NOT release the grant; only termination or abort releases it.
REQ-022 Requests arriving during RUN or RELEASE SHALL be held by nack only (not stored); they are evaluated in the first IDLE cycle.
REQ-023 The grant pointer SHALL update in the RUN->RELEASE transition cycle.
- Simultaneous termination and new requests SHALL be arbitrated in IDLE from the updated pointer.
- A single persistent requester SHALL be regranted, with a fixed 2-cycle gap (RELEASE plus IDLE).
REQ-024 Watchdog:
- An 8-bit counter SHALL clear on entry to RUN and on every accepted beat (v=1, I_BTk.n=0).
- It SHALL increment on every other RUN cycle.
- When it reaches TIMEOUT, the FSM SHALL go to RELEASE and O_Abort SHALL pulse for one cycle.

Reset
REQ-025 Reset values:
- state IDLE; grant pointer 0; watchdog counter 0.
- O_Grant 0, O_Grant_ID 0, O_Busy 0, O_Abort 0, O_FTk all-zero.
- every O_Req_BTk with n=1 and other fields 0.
REQ-026 Reset asserted mid-RUN SHALL drop the grant immediately (asynchronously), with no termination or abort pulse.

Configuration
REQ-027 Macro IF_REQ_ARBITER_WATCHDOG_EN:
- Defined: REQ-024 is implemented.
- Undefined: no counter; O_Abort tied 0; RUN exits only on termination (REQ-019).

Verification
REQ-028 Single request: reset, then I_Header=4'b0010 with 3 beats, last beat v&a&r -> O_Grant=0010 one cycle later; 3 beats on O_FTk; O_Busy low 2 cycles after the last beat.
REQ-029 All requesting: I_Header=4'b1111 held, each port sends a 2-beat burst -> grant order 0,1,2,3,0; other ports see n=1 throughout.
REQ-030 Backpressure: I_BTk.n=1 during the granted terminal beat for 5 cycles -> grant held; RELEASE only in the cycle after n drops.
REQ-031 Watchdog (macro defined, TIMEOUT=4): granted port idle -> O_Abort pulses once, 4 cycles after the last accepted beat; next requester granted. With the macro undefined -> grant held indefinitely.
REQ-032 Reset mid-RUN: assert reset during beat 2 of 4 -> O_Grant=0 and all nacks high immediately; after release the pointer restarts at 0 and port 0 is granted first.
